// File: rtl/taxi_mac_pause_pkg.sv
// Shared constants and types for the receive-side pause controller.
//   FRAC_W_DEFAULT : default number of fractional bits in timers and step
//   QUANTA_W       : width of one pause-quanta value carried in a frame
//   LFC_OPCODE     : nominal 802.3x pause opcode
//   PFC_OPCODE     : nominal 802.1Qbb priority pause opcode
//   PFC_PRIO_CNT   : number of PFC priority classes
//   pause_timer_t  : timer type for the default fractional width
package taxi_mac_pause_pkg;

  localparam int FRAC_W_DEFAULT = 8;
  localparam int QUANTA_W       = 16;
  localparam int PFC_PRIO_CNT   = 8;

  localparam logic [15:0] LFC_OPCODE = 16'h0001;
  localparam logic [15:0] PFC_OPCODE = 16'h0101;

  typedef logic [QUANTA_W+FRAC_W_DEFAULT-1:0] pause_timer_t;

endpackage

// File: rtl/taxi_mac_pause_ctrl_rx_if.sv
// MAC control frame side channel from taxi_mac_ctrl_rx.
//   mcf_valid  : one-cycle strobe, a control frame was accepted upstream
//   mcf_opcode : control opcode of that frame
//   mcf_params : parameter bytes, byte k at [8k+7:8k], byte 0 first on the wire
// Handshake: strobe-only. There is no ready; the consumer must take the frame
// in the cycle mcf_valid is high, and opcode/params are only meaningful then.
// modport master drives the channel, modport slave consumes it.
interface taxi_mac_pause_ctrl_rx_if #(
  parameter int MCF_PARAMS_SIZE = 18
);

  logic                         mcf_valid;
  logic [15:0]                  mcf_opcode;
  logic [MCF_PARAMS_SIZE*8-1:0] mcf_params;

  modport master (output mcf_valid, output mcf_opcode, output mcf_params);
  modport slave  (input  mcf_valid, input  mcf_opcode, input  mcf_params);

endinterface

// File: rtl/taxi_mac_pause_timer.sv
// One pause-quanta countdown timer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force timer to 0 (class disabled); highest priority
//   load       : load value<<FRAC_W; beats the same-cycle decrement
//   value      : pause quanta from the frame
//   step       : fixed-point quanta elapsed per enabled cycle
//   en         : advance enable
//   timer      : current remaining pause, fixed point
//   req        : registered (timer != 0)
module taxi_mac_pause_timer
  import taxi_mac_pause_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       load,
  input  logic [QUANTA_W-1:0]        value,
  input  logic [8+FRAC_W-1:0]        step,
  input  logic                       en,
  output logic [QUANTA_W+FRAC_W-1:0] timer,
  output logic                       req
);

  localparam int TW = QUANTA_W + FRAC_W;

  logic [TW-1:0] timer_next;
  logic [TW-1:0] step_ext;

  assign step_ext = TW'(step);

  // Countdown saturates at zero instead of wrapping when step overshoots.
  always_comb begin
    timer_next = timer;
    if (clear) begin
      timer_next = '0;
    end else if (load) begin
      timer_next = TW'(value) << FRAC_W;
    end else if (en) begin
      timer_next = (timer > step_ext) ? (timer - step_ext) : '0;
    end
  end

  // req is registered from the next value so it moves in the same cycle
  // as the timer itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      req   <= 1'b0;
    end else begin
      timer <= timer_next;
      req   <= (timer_next != '0);
    end
  end

endmodule

// File: rtl/taxi_mac_pause_ctrl_rx.sv
// Receive-side pause controller: decodes LFC and PFC control frames from the
// mcf side channel, loads per-class pause timers and drives pause requests
// toward the TX scheduler.
//   clk, rst_n          : clock, asynchronous active-low reset
//   mcf                 : control frame side channel (slave)
//   cfg_rx_lfc_opcode/en: LFC opcode and enable
//   cfg_rx_pfc_opcode/en: PFC opcode and enable
//   cfg_quanta_step     : fixed-point quanta per enabled cycle
//   cfg_quanta_clk_en   : timer advance enable
//   rx_lfc_req          : link pause request
//   rx_pfc_req          : per-priority pause request
//   stat_rx_*           : one-cycle statistics pulses
//   dbg_lfc_timer       : LFC timer value
//   dbg_pfc_timer       : PFC timer values, index = priority
module taxi_mac_pause_ctrl_rx
  import taxi_mac_pause_pkg::*;
#(
  parameter int PFC_EN          = 1,
  parameter int MCF_PARAMS_SIZE = 18,
  parameter int FRAC_W          = FRAC_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  taxi_mac_pause_ctrl_rx_if.slave    mcf,
  input  logic [15:0]                cfg_rx_lfc_opcode,
  input  logic                       cfg_rx_lfc_en,
  input  logic [15:0]                cfg_rx_pfc_opcode,
  input  logic                       cfg_rx_pfc_en,
  input  logic [8+FRAC_W-1:0]        cfg_quanta_step,
  input  logic                       cfg_quanta_clk_en,
  output logic                       rx_lfc_req,
  output logic [PFC_PRIO_CNT-1:0]    rx_pfc_req,
  output logic                       stat_rx_lfc_pkt,
  output logic                       stat_rx_lfc_xon,
  output logic                       stat_rx_lfc_xoff,
  output logic                       stat_rx_pfc_pkt,
  output logic [PFC_PRIO_CNT-1:0]    stat_rx_pfc_xon,
  output logic [PFC_PRIO_CNT-1:0]    stat_rx_pfc_xoff,
  output logic [QUANTA_W+FRAC_W-1:0] dbg_lfc_timer,
  output logic [PFC_PRIO_CNT-1:0][QUANTA_W+FRAC_W-1:0] dbg_pfc_timer
);

  localparam int TW = QUANTA_W + FRAC_W;

  logic                lfc_hit;
  logic [QUANTA_W-1:0] lfc_quanta;

  // Quanta are big-endian on the wire: byte 0 is the high byte.
  assign lfc_quanta = {mcf.mcf_params[7:0], mcf.mcf_params[15:8]};
  assign lfc_hit    = mcf.mcf_valid && cfg_rx_lfc_en &&
                      (mcf.mcf_opcode == cfg_rx_lfc_opcode);

  taxi_mac_pause_timer #(.FRAC_W(FRAC_W)) u_lfc_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!cfg_rx_lfc_en),
    .load  (lfc_hit),
    .value (lfc_quanta),
    .step  (cfg_quanta_step),
    .en    (cfg_quanta_clk_en),
    .timer (dbg_lfc_timer),
    .req   (rx_lfc_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rx_lfc_pkt  <= 1'b0;
      stat_rx_lfc_xon  <= 1'b0;
      stat_rx_lfc_xoff <= 1'b0;
    end else begin
      stat_rx_lfc_pkt  <= lfc_hit;
      stat_rx_lfc_xon  <= lfc_hit && (lfc_quanta == '0);
      stat_rx_lfc_xoff <= lfc_hit && (lfc_quanta != '0);
    end
  end

  if (PFC_EN != 0) begin : g_pfc
    logic                                    pfc_hit;
    logic [PFC_PRIO_CNT-1:0]                 pfc_ev;
    logic [PFC_PRIO_CNT-1:0][QUANTA_W-1:0]   pfc_quanta;
    logic [PFC_PRIO_CNT-1:0]                 pfc_load;

    // If both opcodes are configured identically, the frame is treated as LFC.
    assign pfc_hit = mcf.mcf_valid && cfg_rx_pfc_en &&
                     (mcf.mcf_opcode == cfg_rx_pfc_opcode) && !lfc_hit;
    // Class-enable vector is {byte0, byte1}; only its low byte maps to classes.
    assign pfc_ev  = mcf.mcf_params[15:8];

    for (genvar i = 0; i < PFC_PRIO_CNT; i++) begin : g_prio
      assign pfc_quanta[i] = {mcf.mcf_params[8*(2+2*i) +: 8],
                              mcf.mcf_params[8*(3+2*i) +: 8]};
      assign pfc_load[i]   = pfc_hit && pfc_ev[i];

      taxi_mac_pause_timer #(.FRAC_W(FRAC_W)) u_pfc_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!cfg_rx_pfc_en),
        .load  (pfc_load[i]),
        .value (pfc_quanta[i]),
        .step  (cfg_quanta_step),
        .en    (cfg_quanta_clk_en),
        .timer (dbg_pfc_timer[i]),
        .req   (rx_pfc_req[i])
      );
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stat_rx_pfc_pkt  <= 1'b0;
        stat_rx_pfc_xon  <= '0;
        stat_rx_pfc_xoff <= '0;
      end else begin
        stat_rx_pfc_pkt <= pfc_hit;
        for (int i = 0; i < PFC_PRIO_CNT; i++) begin
          stat_rx_pfc_xon[i]  <= pfc_load[i] && (pfc_quanta[i] == '0);
          stat_rx_pfc_xoff[i] <= pfc_load[i] && (pfc_quanta[i] != '0);
        end
      end
    end
  end else begin : g_no_pfc
    assign rx_pfc_req       = '0;
    assign stat_rx_pfc_pkt  = 1'b0;
    assign stat_rx_pfc_xon  = '0;
    assign stat_rx_pfc_xoff = '0;
    assign dbg_pfc_timer    = '{default: TW'(0)};
  end

endmodule

// File: tb/tb_taxi_mac_pause_ctrl_rx.sv
module tb_taxi_mac_pause_ctrl_rx;
  import taxi_mac_pause_pkg::*;

  localparam int FRAC_W = 8;
  localparam int TW     = QUANTA_W + FRAC_W;
  localparam int PSIZE  = 18;
  localparam int PW     = PSIZE * 8;
  localparam int W      = 1 + 8 + 4 + 8 + 8 + TW;
  localparam int ONE_Q  = 1 << FRAC_W;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  taxi_mac_pause_ctrl_rx_if #(.MCF_PARAMS_SIZE(PSIZE)) mcf_if ();

  logic [15:0]       cfg_rx_lfc_opcode;
  logic              cfg_rx_lfc_en;
  logic [15:0]       cfg_rx_pfc_opcode;
  logic              cfg_rx_pfc_en;
  logic [8+FRAC_W-1:0] cfg_quanta_step;
  logic              cfg_quanta_clk_en;
  logic              rx_lfc_req;
  logic [7:0]        rx_pfc_req;
  logic              stat_rx_lfc_pkt, stat_rx_lfc_xon, stat_rx_lfc_xoff, stat_rx_pfc_pkt;
  logic [7:0]        stat_rx_pfc_xon, stat_rx_pfc_xoff;
  logic [TW-1:0]     dbg_lfc_timer;
  logic [7:0][TW-1:0] dbg_pfc_timer;

  taxi_mac_pause_ctrl_rx #(.PFC_EN(1), .MCF_PARAMS_SIZE(PSIZE), .FRAC_W(FRAC_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mcf               (mcf_if.slave),
    .cfg_rx_lfc_opcode (cfg_rx_lfc_opcode),
    .cfg_rx_lfc_en     (cfg_rx_lfc_en),
    .cfg_rx_pfc_opcode (cfg_rx_pfc_opcode),
    .cfg_rx_pfc_en     (cfg_rx_pfc_en),
    .cfg_quanta_step   (cfg_quanta_step),
    .cfg_quanta_clk_en (cfg_quanta_clk_en),
    .rx_lfc_req        (rx_lfc_req),
    .rx_pfc_req        (rx_pfc_req),
    .stat_rx_lfc_pkt   (stat_rx_lfc_pkt),
    .stat_rx_lfc_xon   (stat_rx_lfc_xon),
    .stat_rx_lfc_xoff  (stat_rx_lfc_xoff),
    .stat_rx_pfc_pkt   (stat_rx_pfc_pkt),
    .stat_rx_pfc_xon   (stat_rx_pfc_xon),
    .stat_rx_pfc_xoff  (stat_rx_pfc_xoff),
    .dbg_lfc_timer     (dbg_lfc_timer),
    .dbg_pfc_timer     (dbg_pfc_timer)
  );

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  bit toggle_en = 0;

  // reference model: remaining pause per class in 1/ONE_Q quanta; index 8 = LFC
  int rem[9];

  function automatic int advance(input int r, input int step);
    int left;
    left = r - step;
    return (left < 0) ? 0 : left;
  endfunction

  function automatic logic [W-1:0] act_vec();
    return {rx_lfc_req, rx_pfc_req, stat_rx_lfc_pkt, stat_rx_lfc_xon, stat_rx_lfc_xoff,
            stat_rx_pfc_pkt, stat_rx_pfc_xon, stat_rx_pfc_xoff, dbg_lfc_timer};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: called at a negedge with inputs already set; predicts the
  // outputs after the coming posedge, then waits for the next negedge.
  task automatic cycle();
    logic [W-1:0] e;
    bit lfc_hit, pfc_hit;
    logic [15:0] lq, qi;
    logic [7:0] ev, pxon, pxoff, preq;
    int step;
    if (toggle_en) cfg_quanta_clk_en = ~cfg_quanta_clk_en;
    step    = int'(cfg_quanta_step);
    lfc_hit = mcf_if.mcf_valid && cfg_rx_lfc_en && (mcf_if.mcf_opcode == cfg_rx_lfc_opcode);
    pfc_hit = mcf_if.mcf_valid && cfg_rx_pfc_en && (mcf_if.mcf_opcode == cfg_rx_pfc_opcode) && !lfc_hit;
    lq = {mcf_if.mcf_params[7:0], mcf_if.mcf_params[15:8]};
    ev = mcf_if.mcf_params[15:8];
    if (!cfg_rx_lfc_en) rem[8] = 0;
    else if (lfc_hit) rem[8] = int'(lq) * ONE_Q;
    else if (cfg_quanta_clk_en) rem[8] = advance(rem[8], step);
    pxon = '0;
    pxoff = '0;
    for (int i = 0; i < 8; i++) begin
      qi = {mcf_if.mcf_params[8*(2+2*i) +: 8], mcf_if.mcf_params[8*(3+2*i) +: 8]};
      if (!cfg_rx_pfc_en) rem[i] = 0;
      else if (pfc_hit && ev[i]) begin
        rem[i]   = int'(qi) * ONE_Q;
        pxon[i]  = (qi == 0);
        pxoff[i] = (qi != 0);
      end else if (cfg_quanta_clk_en) rem[i] = advance(rem[i], step);
      preq[i] = (rem[i] != 0);
    end
    e = {(rem[8] != 0), preq, lfc_hit, lfc_hit && (lq == 0), lfc_hit && (lq != 0),
         pfc_hit, pxon, pxoff, TW'(rem[8])};
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send_raw(input logic [15:0] op, input logic [PW-1:0] p);
    mcf_if.mcf_valid  = 1'b1;
    mcf_if.mcf_opcode = op;
    mcf_if.mcf_params = p;
    cycle();
    mcf_if.mcf_valid  = 1'b0;
  endtask

  function automatic logic [PW-1:0] junk();
    logic [PW-1:0] p;
    for (int k = 0; k < PSIZE; k++) p[8*k +: 8] = 8'($urandom_range(0, 255));
    return p;
  endfunction

  task automatic send_lfc(input logic [15:0] q);
    logic [PW-1:0] p;
    p = junk();
    p[7:0]  = q[15:8];
    p[15:8] = q[7:0];
    send_raw(cfg_rx_lfc_opcode, p);
  endtask

  task automatic send_pfc(input logic [7:0] ev, input logic [7:0][15:0] q);
    logic [PW-1:0] p;
    p = '0;
    p[15:8] = ev;
    for (int i = 0; i < 8; i++) begin
      p[8*(2+2*i) +: 8] = q[i][15:8];
      p[8*(3+2*i) +: 8] = q[i][7:0];
    end
    send_raw(cfg_rx_pfc_opcode, p);
  endtask

  // Counts consecutive post-edge samples with the chosen request high.
  task automatic measure(input int which, output int cnt);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      if ((which == 8) ? rx_lfc_req : rx_pfc_req[which]) cnt++;
      else break;
      cycle();
    end
  endtask

  // monitor: compares every predicted cycle
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("outputs", 64'(act_vec()), 64'(e));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    int cnt, c0, c2, cx;
    logic [7:0][15:0] q;
    logic [8+FRAC_W-1:0] steps[5];
    steps = '{16'h0100, 16'h0080, 16'h0040, 16'h0180, 16'h0000};

    mcf_if.mcf_valid  = 1'b0;
    mcf_if.mcf_opcode = '0;
    mcf_if.mcf_params = '0;
    cfg_rx_lfc_opcode = LFC_OPCODE;
    cfg_rx_pfc_opcode = PFC_OPCODE;
    cfg_rx_lfc_en     = 1'b1;
    cfg_rx_pfc_en     = 1'b1;
    cfg_quanta_step   = 16'h0100;
    cfg_quanta_clk_en = 1'b1;
    for (int i = 0; i < 9; i++) rem[i] = 0;

    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'(act_vec()), 64'd0);
    rst_n = 1'b1;
    idle(3);

    // LFC 16 quanta at one quanta per cycle
    send_lfc(16'h0010);
    chk("lfc_xoff_pulse", 64'(stat_rx_lfc_xoff), 64'd1);
    measure(8, cnt);
    chk("lfc_duration", 64'(cnt), 64'd16);

    // long pause then XON ten cycles later
    send_lfc(16'hFFFF);
    idle(9);
    send_lfc(16'h0000);
    chk("xon_req", 64'(rx_lfc_req), 64'd0);
    chk("xon_pulse", 64'(stat_rx_lfc_xon), 64'd1);
    idle(2);

    // PFC: class 5 preloaded, then ev=0x05 q0=4 q2=8
    q = '0;
    q[5] = 16'd30;
    send_pfc(8'h20, q);
    idle(2);
    q = '0;
    q[0] = 16'd4;
    q[2] = 16'd8;
    q[5] = 16'd3;
    send_pfc(8'h05, q);
    c0 = 0; c2 = 0; cx = 0;
    for (int k = 0; k < 40; k++) begin
      c0 += int'(rx_pfc_req[0]);
      c2 += int'(rx_pfc_req[2]);
      cx += int'(|(rx_pfc_req & 8'b1101_1010));
      cycle();
    end
    chk("pfc0_duration", 64'(c0), 64'd4);
    chk("pfc2_duration", 64'(c2), 64'd8);
    chk("pfc_others", 64'(cx), 64'd0);

    // load colliding with the last decrement step
    send_lfc(16'd2);
    idle(1);
    send_lfc(16'd5);
    chk("collision_timer", 64'(dbg_lfc_timer), 64'(5 * ONE_Q));
    idle(8);

    // 50% clock enable doubles the pause
    cfg_quanta_clk_en = 1'b0;
    toggle_en = 1;
    send_lfc(16'h0010);
    measure(8, cnt);
    toggle_en = 0;
    cfg_quanta_clk_en = 1'b1;
    chk("half_rate_duration", 64'(cnt), 64'd32);

    // step 0 freezes the timer
    cfg_quanta_step = '0;
    send_lfc(16'd3);
    idle(20);
    chk("frozen_req", 64'(rx_lfc_req), 64'd1);
    chk("frozen_timer", 64'(dbg_lfc_timer), 64'(3 * ONE_Q));
    cfg_quanta_step = 16'h0100;
    idle(5);

    // PFC enable dropped mid-pause
    q = '0;
    q[1] = 16'd50;
    send_pfc(8'h02, q);
    idle(3);
    cfg_rx_pfc_en = 1'b0;
    cycle();
    chk("pfc_disable_req", 64'(rx_pfc_req), 64'd0);
    send_pfc(8'hFF, q);
    chk("pfc_disabled_stat", 64'(stat_rx_pfc_pkt), 64'd0);
    cfg_rx_pfc_en = 1'b1;
    idle(2);

    // unmatched opcode
    send_raw(16'h0002, junk());
    chk("unmatched_stats", 64'({stat_rx_lfc_pkt, stat_rx_pfc_pkt, stat_rx_pfc_xoff, stat_rx_lfc_xoff}), 64'd0);
    chk("unmatched_req", 64'({rx_lfc_req, rx_pfc_req}), 64'd0);

    // both opcodes identical: LFC takes the frame
    cfg_rx_pfc_opcode = cfg_rx_lfc_opcode;
    send_lfc(16'h0707);
    chk("misconfig_pfc_pkt", 64'(stat_rx_pfc_pkt), 64'd0);
    chk("misconfig_lfc_pkt", 64'(stat_rx_lfc_pkt), 64'd1);
    cfg_rx_pfc_opcode = PFC_OPCODE;
    idle(2);

    // asynchronous reset mid-pause
    send_lfc(16'd100);
    idle(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 64'(act_vec()), 64'd0);
    chk("async_reset_pfc", 64'(rx_pfc_req), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) rem[i] = 0;
    idle(3);
    chk("post_reset_req", 64'(rx_lfc_req), 64'd0);

    // randomized traffic against the reference model
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 49) == 0) cfg_quanta_step = steps[$urandom_range(0, 4)];
      if ($urandom_range(0, 59) == 0) cfg_rx_pfc_en = ~cfg_rx_pfc_en;
      if ($urandom_range(0, 79) == 0) cfg_rx_lfc_en = ~cfg_rx_lfc_en;
      cfg_quanta_clk_en = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0, 1: send_lfc(16'($urandom_range(0, 24)));
        2, 3: begin
          for (int i = 0; i < 8; i++) q[i] = 16'($urandom_range(0, 24));
          send_pfc(8'($urandom_range(0, 255)), q);
        end
        4: send_raw(16'($urandom_range(2, 255)), junk());
        default: cycle();
      endcase
    end
    cfg_rx_lfc_en = 1'b1;
    cfg_rx_pfc_en = 1'b1;
    cfg_quanta_clk_en = 1'b1;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
